// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/write-back controller: widths, opcodes,
// ALU select codes, FSM state encodings and the instruction word layout.
package alu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NREG    = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 8;
  localparam int unsigned SEL_W   = 3;

  localparam logic [OP_W-1:0] OP_LOADI = 8'h00;
  localparam logic [OP_W-1:0] OP_MOV   = 8'h01;
  localparam logic [OP_W-1:0] OP_ADD   = 8'h02;
  localparam logic [OP_W-1:0] OP_SUB   = 8'h03;
  localparam logic [OP_W-1:0] OP_AND   = 8'h04;
  localparam logic [OP_W-1:0] OP_OR    = 8'h05;

  localparam logic [SEL_W-1:0] SEL_FWD = 3'b000;
  localparam logic [SEL_W-1:0] SEL_ADD = 3'b001;
  localparam logic [SEL_W-1:0] SEL_AND = 3'b010;
  localparam logic [SEL_W-1:0] SEL_OR  = 3'b011;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  // Instruction word: [31:24] opcode, [18:16] dest, [10:8] src1, [7:0] src2/imm
  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [4:0]        rsvd_hi;
    logic [ADDR_W-1:0] dest;
    logic [4:0]        rsvd_lo;
    logic [ADDR_W-1:0] src1;
    logic [DATA_W-1:0] src2_imm;
  } instr_t;

  // Two's-complement negation so SUB can reuse the ALU adder
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return DATA_W'(~v + DATA_W'(1));
  endfunction

endpackage

// File: rtl/reg_file_8x8.sv
// 8x8 register file: two async read ports, one async debug read port,
// one synchronous write port and a synchronous active-low clear.
module reg_file_8x8
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rdata1_c,
  output logic [DATA_W-1:0] rdata2_c,
  output logic [DATA_W-1:0] dbg_data_c
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1_c   = regs[raddr1];
  assign rdata2_c   = regs[raddr2];
  assign dbg_data_c = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller for the 8-bit ALU: accepts an instruction, reads
// operands, holds them for ALU_WAIT cycles, samples the result and writes it back.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned ALU_WAIT = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               INSTR_VALID,
  output logic               INSTR_READY,
  output logic [DATA_W-1:0]  ALU_DATA1,
  output logic [DATA_W-1:0]  ALU_DATA2,
  output logic [SEL_W-1:0]   ALU_SELECT,
  input  logic [DATA_W-1:0]  ALU_RESULT,
  output logic               WB_EN,
  output logic [ADDR_W-1:0]  WB_ADDR,
  output logic [DATA_W-1:0]  WB_DATA,
  output logic               ILLEGAL,
  input  logic [ADDR_W-1:0]  DBG_ADDR,
  output logic [DATA_W-1:0]  DBG_DATA
);

  localparam int unsigned CNT_W = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  instr_t            instr_q, instr_d;
  logic              ready_d, wb_en_d, illegal_d;
  logic [DATA_W-1:0] data1_d, data2_d, wb_data_d;
  logic [SEL_W-1:0]  sel_d;
  logic [ADDR_W-1:0] wb_addr_d;
  logic [DATA_W-1:0] rd1, rd2;

  // Reserved instruction bits are latched with the word but never decoded
  logic unused_rsvd;
  assign unused_rsvd = ^{instr_q.rsvd_hi, instr_q.rsvd_lo};

  reg_file_8x8 u_rf (
    .clk        (CLK),
    .rst_n      (RESET),
    .we         (WB_EN),
    .waddr      (WB_ADDR),
    .wdata      (WB_DATA),
    .raddr1     (instr_q.src1),
    .raddr2     (instr_q.src2_imm[ADDR_W-1:0]),
    .dbg_addr   (DBG_ADDR),
    .rdata1_c   (rd1),
    .rdata2_c   (rd2),
    .dbg_data_c (DBG_DATA)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      instr_q     <= '0;
      INSTR_READY <= 1'b0;
      ALU_DATA1   <= '0;
      ALU_DATA2   <= '0;
      ALU_SELECT  <= SEL_FWD;
      WB_EN       <= 1'b0;
      WB_ADDR     <= '0;
      WB_DATA     <= '0;
      ILLEGAL     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      INSTR_READY <= ready_d;
      ALU_DATA1   <= data1_d;
      ALU_DATA2   <= data2_d;
      ALU_SELECT  <= sel_d;
      WB_EN       <= wb_en_d;
      WB_ADDR     <= wb_addr_d;
      WB_DATA     <= wb_data_d;
      ILLEGAL     <= illegal_d;
    end
  end

  // Next-state and next-output logic; the write-back in WB happens in the reg file
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    ready_d   = 1'b0;
    data1_d   = ALU_DATA1;
    data2_d   = ALU_DATA2;
    sel_d     = ALU_SELECT;
    wb_en_d   = 1'b0;
    wb_addr_d = WB_ADDR;
    wb_data_d = WB_DATA;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (INSTR_VALID && INSTR_READY) begin
          instr_d = instr_t'(INSTR);
          state_d = S_DECODE;
          ready_d = 1'b0;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        cnt_d   = CNT_W'(ALU_WAIT - 1);
        data1_d = rd1;
        case (instr_q.opcode)
          OP_LOADI: begin sel_d = SEL_FWD; data2_d = instr_q.src2_imm; end
          OP_MOV:   begin sel_d = SEL_FWD; data2_d = rd2;              end
          OP_ADD:   begin sel_d = SEL_ADD; data2_d = rd2;              end
          OP_SUB:   begin sel_d = SEL_ADD; data2_d = negate(rd2);      end
          OP_AND:   begin sel_d = SEL_AND; data2_d = rd2;              end
          OP_OR:    begin sel_d = SEL_OR;  data2_d = rd2;              end
          default: begin
            // Undefined opcode: drop it, leave the ALU interface untouched
            state_d   = S_IDLE;
            cnt_d     = cnt_q;
            data1_d   = ALU_DATA1;
            ready_d   = 1'b1;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d   = S_WB;
          wb_en_d   = 1'b1;
          wb_addr_d = instr_q.dest;
          wb_data_d = ALU_RESULT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 8-bit ALU on the far side.
module tb_alu_issue_ctrl;

  localparam int unsigned ALU_WAIT = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [7:0]  ALU_DATA1, ALU_DATA2, ALU_RESULT;
  logic [2:0]  ALU_SELECT;
  logic        WB_EN, ILLEGAL;
  logic [2:0]  WB_ADDR, DBG_ADDR;
  logic [7:0]  WB_DATA, DBG_DATA;

  int checks = 0;
  int errors = 0;

  logic [2:0] r_sel, r_wa;
  logic [7:0] r_d1, r_d2, r_wd, r_dbg;
  int         r_wbc, r_busy;
  logic       r_stable, r_ill;

  always #5 CLK = ~CLK;

  alu_issue_ctrl #(.ALU_WAIT(ALU_WAIT)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2),
    .ALU_SELECT(ALU_SELECT), .ALU_RESULT(ALU_RESULT), .WB_EN(WB_EN),
    .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .ILLEGAL(ILLEGAL),
    .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
  );

  // Behavioural ALU: FORWARD passes operand 2
  always_comb begin
    case (ALU_SELECT)
      3'b000:  ALU_RESULT = ALU_DATA2;
      3'b001:  ALU_RESULT = ALU_DATA1 + ALU_DATA2;
      3'b010:  ALU_RESULT = ALU_DATA1 & ALU_DATA2;
      3'b011:  ALU_RESULT = ALU_DATA1 | ALU_DATA2;
      default: ALU_RESULT = 8'h00;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [7:0] s2);
    return {op, 5'b0, d, 5'b0, s1, s2};
  endfunction

  // Issue one instruction and record what the controller does until READY returns
  task automatic exec_instr(input logic [31:0] ins);
    int t = 0;
    r_sel = '0; r_d1 = '0; r_d2 = '0; r_wa = '0; r_wd = '0; r_dbg = '0;
    r_wbc = 0; r_busy = 0; r_stable = 1'b1; r_ill = 1'b0;
    INSTR = ins; INSTR_VALID = 1'b1;
    while (!INSTR_READY && t < 20) begin step(); t++; end
    step();
    INSTR_VALID = 1'b0; INSTR = 32'hDEAD_BEEF;
    while (!INSTR_READY && r_busy < 12) begin
      if (r_busy == 1) begin
        r_sel = ALU_SELECT; r_d1 = ALU_DATA1; r_d2 = ALU_DATA2;
      end else if (r_busy > 1 && r_busy <= int'(ALU_WAIT) &&
                   {ALU_SELECT, ALU_DATA1, ALU_DATA2} !== {r_sel, r_d1, r_d2}) begin
        r_stable = 1'b0;
      end
      if (ILLEGAL) r_ill = 1'b1;
      if (WB_EN) begin r_wbc++; r_wa = WB_ADDR; r_wd = WB_DATA; r_dbg = DBG_DATA; end
      r_busy++;
      step();
    end
    if (ILLEGAL) r_ill = 1'b1;
    if (WB_EN) r_wbc++;
  endtask

  task automatic test_reset();
    RESET = 1'b0; INSTR_VALID = 1'b0; INSTR = '0; DBG_ADDR = '0;
    repeat (3) step();
    checks++; if (INSTR_READY !== 1'b0) begin errors++; $display("FAIL rst_ready got %0h exp 0", INSTR_READY); end
    checks++; if ({ALU_DATA1, ALU_DATA2, ALU_SELECT} !== 19'h0) begin errors++; $display("FAIL rst_alu got %0h exp 0", {ALU_DATA1, ALU_DATA2, ALU_SELECT}); end
    checks++; if ({WB_EN, WB_ADDR, WB_DATA, ILLEGAL} !== 13'h0) begin errors++; $display("FAIL rst_wb got %0h exp 0", {WB_EN, WB_ADDR, WB_DATA, ILLEGAL}); end
    for (int i = 0; i < 8; i++) begin
      DBG_ADDR = 3'(i); #1;
      checks++; if (DBG_DATA !== 8'h00) begin errors++; $display("FAIL rst_reg%0d got %0h exp 0", i, DBG_DATA); end
    end
    RESET = 1'b1;
    step();
    checks++; if (INSTR_READY !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0h exp 1", INSTR_READY); end
  endtask

  task automatic test_add();
    exec_instr(mk(8'h00, 3'd1, 3'd0, 8'h05));
    checks++; if ({r_wa, r_wd} !== {3'd1, 8'h05}) begin errors++; $display("FAIL loadi_r1 got %0h exp %0h", {r_wa, r_wd}, {3'd1, 8'h05}); end
    exec_instr(mk(8'h00, 3'd2, 3'd0, 8'h03));
    checks++; if ({r_wa, r_wd} !== {3'd2, 8'h03}) begin errors++; $display("FAIL loadi_r2 got %0h exp %0h", {r_wa, r_wd}, {3'd2, 8'h03}); end
    exec_instr(mk(8'h02, 3'd3, 3'd1, 8'h02));
    checks++; if ({r_sel, r_d1, r_d2} !== {3'b001, 8'h05, 8'h03}) begin errors++; $display("FAIL add_operands got %0h exp %0h", {r_sel, r_d1, r_d2}, {3'b001, 8'h05, 8'h03}); end
    checks++; if ({r_wa, r_wd} !== {3'd3, 8'h08}) begin errors++; $display("FAIL add_wb got %0h exp %0h", {r_wa, r_wd}, {3'd3, 8'h08}); end
    checks++; if (r_busy !== ALU_WAIT + 2) begin errors++; $display("FAIL add_ready_low got %0d exp %0d", r_busy, ALU_WAIT + 2); end
    checks++; if (r_stable !== 1'b1) begin errors++; $display("FAIL add_operands_stable got %0b exp 1", r_stable); end
    checks++; if (r_wbc !== 1) begin errors++; $display("FAIL add_wb_pulses got %0d exp 1", r_wbc); end
    DBG_ADDR = 3'd3; #1;
    checks++; if (DBG_DATA !== 8'h08) begin errors++; $display("FAIL add_dbg_r3 got %0h exp 08", DBG_DATA); end
  endtask

  task automatic test_sub();
    exec_instr(mk(8'h03, 3'd4, 3'd2, 8'h01));
    checks++; if ({r_sel, r_d1, r_d2} !== {3'b001, 8'h03, 8'hFB}) begin errors++; $display("FAIL sub42_operands got %0h exp %0h", {r_sel, r_d1, r_d2}, {3'b001, 8'h03, 8'hFB}); end
    checks++; if ({r_wa, r_wd} !== {3'd4, 8'hFE}) begin errors++; $display("FAIL sub42_wb got %0h exp %0h", {r_wa, r_wd}, {3'd4, 8'hFE}); end
    exec_instr(mk(8'h03, 3'd5, 3'd1, 8'h02));
    checks++; if ({r_d1, r_d2} !== {8'h05, 8'hFD}) begin errors++; $display("FAIL sub51_operands got %0h exp %0h", {r_d1, r_d2}, {8'h05, 8'hFD}); end
    checks++; if ({r_wa, r_wd} !== {3'd5, 8'h02}) begin errors++; $display("FAIL sub51_wb got %0h exp %0h", {r_wa, r_wd}, {3'd5, 8'h02}); end
  endtask

  task automatic test_wrap();
    exec_instr(mk(8'h00, 3'd6, 3'd0, 8'hFF));
    exec_instr(mk(8'h00, 3'd7, 3'd0, 8'h01));
    DBG_ADDR = 3'd6;
    // Reserved bits and high src2 bits set; only the listed address bits count
    exec_instr(mk(8'h02, 3'd6, 3'd6, 8'hF7) | 32'h00F8_F800);
    checks++; if ({r_d1, r_d2} !== {8'hFF, 8'h01}) begin errors++; $display("FAIL wrap_operands got %0h exp %0h", {r_d1, r_d2}, {8'hFF, 8'h01}); end
    checks++; if ({r_wa, r_wd} !== {3'd6, 8'h00}) begin errors++; $display("FAIL wrap_wb got %0h exp %0h", {r_wa, r_wd}, {3'd6, 8'h00}); end
    checks++; if (r_dbg !== 8'hFF) begin errors++; $display("FAIL wrap_dbg_in_wb got %0h exp ff", r_dbg); end
    #1;
    checks++; if (DBG_DATA !== 8'h00) begin errors++; $display("FAIL wrap_dbg_after got %0h exp 00", DBG_DATA); end
  endtask

  task automatic test_logic();
    exec_instr(mk(8'h00, 3'd1, 3'd0, 8'h0F));
    exec_instr(mk(8'h00, 3'd2, 3'd0, 8'h59));
    exec_instr(mk(8'h04, 3'd3, 3'd1, 8'h02));
    checks++; if ({r_sel, r_wd} !== {3'b010, 8'h09}) begin errors++; $display("FAIL and got %0h exp %0h", {r_sel, r_wd}, {3'b010, 8'h09}); end
    exec_instr(mk(8'h00, 3'd2, 3'd0, 8'h79));
    exec_instr(mk(8'h05, 3'd3, 3'd1, 8'h02));
    checks++; if ({r_sel, r_wd} !== {3'b011, 8'h7F}) begin errors++; $display("FAIL or got %0h exp %0h", {r_sel, r_wd}, {3'b011, 8'h7F}); end
    exec_instr(mk(8'h01, 3'd0, 3'd0, 8'h03));
    checks++; if ({r_sel, r_d1, r_d2, r_wa, r_wd} !== {3'b000, 8'h00, 8'h7F, 3'd0, 8'h7F}) begin errors++; $display("FAIL mov got %0h exp %0h", {r_sel, r_d1, r_d2, r_wa, r_wd}, {3'b000, 8'h00, 8'h7F, 3'd0, 8'h7F}); end
  endtask

  task automatic test_illegal();
    logic [7:0] exp_r [8];
    exp_r = '{8'h7F, 8'h0F, 8'h79, 8'h7F, 8'hFE, 8'h02, 8'h00, 8'h01};
    exec_instr(mk(8'h07, 3'd4, 3'd1, 8'h02));
    checks++; if ({r_ill, r_wbc} !== {1'b1, 32'd0}) begin errors++; $display("FAIL ill07_flags got ill=%0b wb=%0d exp ill=1 wb=0", r_ill, r_wbc); end
    checks++; if (r_busy !== 1) begin errors++; $display("FAIL ill07_ready_low got %0d exp 1", r_busy); end
    checks++; if ({ALU_SELECT, ALU_DATA1, ALU_DATA2} !== {3'b000, 8'h00, 8'h7F}) begin errors++; $display("FAIL ill07_alu_held got %0h exp %0h", {ALU_SELECT, ALU_DATA1, ALU_DATA2}, {3'b000, 8'h00, 8'h7F}); end
    step();
    checks++; if ({ILLEGAL, INSTR_READY, WB_EN} !== 3'b010) begin errors++; $display("FAIL ill07_pulse_end got %0b exp 010", {ILLEGAL, INSTR_READY, WB_EN}); end
    exec_instr(mk(8'h06, 3'd1, 3'd1, 8'h01));
    checks++; if ({r_ill, r_wbc, r_busy} !== {1'b1, 32'd0, 32'd1}) begin errors++; $display("FAIL ill06 got ill=%0b wb=%0d busy=%0d exp 1/0/1", r_ill, r_wbc, r_busy); end
    for (int i = 0; i < 8; i++) begin
      DBG_ADDR = 3'(i); #1;
      checks++; if (DBG_DATA !== exp_r[i]) begin errors++; $display("FAIL ill_reg%0d got %0h exp %0h", i, DBG_DATA, exp_r[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int busy1 = 0;
    int busy2 = 0;
    logic [7:0] wd = '0;
    logic [2:0] wa = '0;
    step();
    INSTR = mk(8'h00, 3'd1, 3'd0, 8'h11); INSTR_VALID = 1'b1;
    step();
    INSTR = mk(8'h02, 3'd2, 3'd1, 8'h01);
    while (!INSTR_READY && busy1 < 12) begin busy1++; step(); end
    checks++; if (busy1 !== ALU_WAIT + 2) begin errors++; $display("FAIL b2b_ready_low1 got %0d exp %0d", busy1, ALU_WAIT + 2); end
    step();
    INSTR_VALID = 1'b0;
    while (!INSTR_READY && busy2 < 12) begin
      if (WB_EN) begin wa = WB_ADDR; wd = WB_DATA; end
      busy2++; step();
    end
    checks++; if (busy2 !== ALU_WAIT + 2) begin errors++; $display("FAIL b2b_ready_low2 got %0d exp %0d", busy2, ALU_WAIT + 2); end
    checks++; if ({wa, wd} !== {3'd2, 8'h22}) begin errors++; $display("FAIL b2b_wb got %0h exp %0h", {wa, wd}, {3'd2, 8'h22}); end
  endtask

  task automatic test_reset_mid();
    int wbc = 0;
    int rdy = 0;
    INSTR = mk(8'h02, 3'd5, 3'd1, 8'h02); INSTR_VALID = 1'b1;
    step();
    INSTR_VALID = 1'b0;
    step();
    if (WB_EN) wbc++;
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (WB_EN) wbc++;
      if (INSTR_READY) rdy++;
    end
    checks++; if (wbc !== 0) begin errors++; $display("FAIL midrst_wb_pulses got %0d exp 0", wbc); end
    checks++; if (rdy !== 0) begin errors++; $display("FAIL midrst_ready_cycles got %0d exp 0", rdy); end
    checks++; if ({ALU_SELECT, ALU_DATA1, ALU_DATA2} !== 19'h0) begin errors++; $display("FAIL midrst_alu got %0h exp 0", {ALU_SELECT, ALU_DATA1, ALU_DATA2}); end
    for (int i = 0; i < 8; i++) begin
      DBG_ADDR = 3'(i); #1;
      checks++; if (DBG_DATA !== 8'h00) begin errors++; $display("FAIL midrst_reg%0d got %0h exp 0", i, DBG_DATA); end
    end
    RESET = 1'b1;
    step();
    checks++; if ({INSTR_READY, WB_EN} !== 2'b10) begin errors++; $display("FAIL midrst_recover got %0b exp 10", {INSTR_READY, WB_EN}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_wrap();
    test_logic();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
